// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: synchronizes the scan clock, advances the digit,
// snapshots the digit data and drives active-low anodes/cathodes. Optional macro: SCAN_GAP_EN.
module seg_scan_ctrl #(
  parameter int unsigned N_DIGITS   = 8,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        pix_clk,
  input  logic [31:0] digits,
  input  logic [7:0]  dp,
  input  logic [7:0]  blank,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [2:0]  digit_sel
);

  localparam logic [2:0] LastSel = 3'(N_DIGITS - 1);

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    s = '1;
    unique case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic       s1_q, s2_q, s3_q;
  logic       adv;
  logic [2:0] sel_q, sel_d;
  logic [3:0] nib_q, nib_d;
  logic       dpb_q, dpb_d;
  logic       blk_q, blk_d;
  logic       valid_q;
  logic [7:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dpn_q, dpn_d;
  logic       gap_active;

  assign adv = s2_q & ~s3_q;

`ifdef SCAN_GAP_EN
  logic [7:0] gap_q, gap_d;

  always_comb begin
    gap_d = gap_q;
    if (adv)             gap_d = 8'(GAP_CYCLES);
    else if (gap_q != 0) gap_d = gap_q - 8'd1;
  end

  always_ff @(posedge clk_in) begin
    if (reset) gap_q <= '0;
    else       gap_q <= gap_d;
  end

  assign gap_active = (gap_q != 8'd0);
`else
  assign gap_active = 1'b0;
`endif

  always_comb begin
    sel_d = sel_q;
    nib_d = nib_q;
    dpb_d = dpb_q;
    blk_d = blk_q;
    if (adv) begin
      sel_d = (sel_q == LastSel) ? 3'd0 : sel_q + 3'd1;
      nib_d = digits[{sel_d, 2'b00} +: 4];
      dpb_d = dp[sel_d];
      blk_d = blank[sel_d];
    end
  end

  // Outputs stay at their reset values until the first advance after reset supplies a snapshot.
  always_comb begin
    an_d  = '1;
    seg_d = '1;
    dpn_d = 1'b1;
    if (valid_q) begin
      seg_d = hex7(nib_q);
      dpn_d = ~dpb_q;
      if (!blk_q && !gap_active) an_d = ~(8'b1 << sel_q);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      sel_q   <= '0;
      nib_q   <= '0;
      dpb_q   <= 1'b0;
      blk_q   <= 1'b1;
      valid_q <= 1'b0;
      an_q    <= '1;
      seg_q   <= '1;
      dpn_q   <= 1'b1;
    end else begin
      s1_q    <= pix_clk;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      sel_q   <= sel_d;
      nib_q   <= nib_d;
      dpb_q   <= dpb_d;
      blk_q   <= blk_d;
      valid_q <= valid_q | adv;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dpn_q   <= dpn_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp_n      = dpn_q;
  assign digit_sel = sel_q;

endmodule
